// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg
// Shared definitions for the input-conditioning debouncer: the FSM state
// encoding and a helper that sizes the stability counter.
// No ports; imported by sync_debounce.

package sync_debounce_pkg;

    // Two-bit state encoding. The low bit marks a "waiting" state and the
    // high bit carries the level currently presented on dout.
    typedef enum logic [1:0] {
        ST_LO      = 2'b00,
        ST_WAIT_HI = 2'b01,
        ST_HI      = 2'b10,
        ST_WAIT_LO = 2'b11
    } db_state_t;

    // Counter width: $clog2 of the stable-cycle count, never less than one bit
    // so a DB_CNT of 1 or 2 still gets a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain
// Plain flop-chain synchronizer bringing an asynchronous level into the clk
// domain. Holds no logic beyond the flops and their synchronous clear.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high clear of every stage
//   d    - asynchronous input level
//   q    - synchronized level (last stage of the chain)

module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] s;

    // Stage 0 samples the raw input; each later stage samples the one before,
    // giving metastability STAGES-1 extra cycles to resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else begin
            s <= {s[STAGES-2:0], d};
        end
    end

    assign q = s[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce
// Synchronizes a raw asynchronous level and debounces it so downstream logic
// (the dual-edge detector) only ever sees a clean synchronous level. dout
// changes only after the synchronized input has disagreed with it for DB_CNT
// consecutive cycles; any break restarts qualification from zero.
// Parameters:
//   SYNC_STAGES - synchronizer depth (>= 2)
//   DB_CNT      - consecutive stable cycles needed to change dout (>= 1)
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   din_async  - raw asynchronous input level
//   dout       - debounced, registered level
//   busy       - registered, high while a candidate change is being qualified

module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din_async,
    output logic dout,
    output logic busy
);

    localparam int               CNT_W    = cnt_width(DB_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               DB_ONE   = (DB_CNT == 1);

    logic             din_s;
    db_state_t        state;
    db_state_t        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din_async),
        .q   (din_s)
    );

    // Next-state and next-count logic. A stable state that sees the opposite
    // level opens a candidate with the count already at one (this cycle is the
    // first matching one). In a waiting state, a return to the current dout
    // level is a bounce and drops the candidate; that check comes before the
    // terminal-count check so a bounce on the final cycle still wins.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_LO: begin
                if (din_s) begin
                    if (DB_ONE) begin
                        state_n = ST_HI;
                        cnt_n   = '0;
                    end else begin
                        state_n = ST_WAIT_HI;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (!din_s) begin
                    state_n = ST_LO;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = ST_HI;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!din_s) begin
                    if (DB_ONE) begin
                        state_n = ST_LO;
                        cnt_n   = '0;
                    end else begin
                        state_n = ST_WAIT_LO;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            ST_WAIT_LO: begin
                if (din_s) begin
                    state_n = ST_HI;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = ST_LO;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = ST_LO;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counter and outputs. dout and busy are decoded from the next
    // state so the registered outputs always agree with the registered state
    // with no extra cycle of lag. Reset discards any partial qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LO;
            cnt   <= '0;
            dout  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dout  <= (state_n == ST_HI) || (state_n == ST_WAIT_LO);
            busy  <= (state_n == ST_WAIT_HI) || (state_n == ST_WAIT_LO);
        end
    end

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce
// Self-checking bench for sync_debounce. Two instances share the same input:
// one with DB_CNT=4 and one with DB_CNT=1, both with two synchronizer stages.
// A reference model tracks, per instance, how many consecutive cycles the
// synchronized input has disagreed with the debounced output.

module tb_sync_debounce;

    localparam int SYNC = 2;
    localparam int DBA  = 4;
    localparam int DBB  = 1;

    logic clk = 1'b0;
    logic rst;
    logic din_async;
    logic dout_a, busy_a;
    logic dout_b, busy_b;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit pipe [SYNC];
    bit m_dout_a, m_dout_b;
    int run_a, run_b;

    // Observation bookkeeping
    int rises_a = 0;
    int rises_b = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    bit busy_b_seen = 1'b0;

    always #5 clk = ~clk;

    sync_debounce #(
        .SYNC_STAGES (SYNC),
        .DB_CNT      (DBA)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .din_async (din_async),
        .dout      (dout_a),
        .busy      (busy_a)
    );

    sync_debounce #(
        .SYNC_STAGES (SYNC),
        .DB_CNT      (DBB)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .din_async (din_async),
        .dout      (dout_b),
        .busy      (busy_b)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Debounce rule: count consecutive disagreeing cycles; once the count
    // reaches db the output flips and counting starts over.
    function automatic void qualify(input bit din_s, input int db, inout bit d, inout int run);
        if (din_s != d) begin
            run++;
            if (run >= db) begin
                d   = ~d;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endfunction

    // One clock edge: advance the model with the inputs present at the edge,
    // then sample the DUT outputs 1 time unit later and compare.
    task automatic tick();
        bit ds;
        @(posedge clk);
        ds = pipe[SYNC-1];
        if (rst) begin
            for (int i = 0; i < SYNC; i++) pipe[i] = 1'b0;
            m_dout_a = 1'b0;
            m_dout_b = 1'b0;
            run_a    = 0;
            run_b    = 0;
        end else begin
            for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = din_async;
            qualify(ds, DBA, m_dout_a, run_a);
            qualify(ds, DBB, m_dout_b, run_b);
        end
        #1;
        checkOutput("dout_a", {31'd0, dout_a}, {31'd0, m_dout_a});
        checkOutput("busy_a", {31'd0, busy_a}, {31'd0, run_a > 0});
        checkOutput("dout_b", {31'd0, dout_b}, {31'd0, m_dout_b});
        checkOutput("busy_b", {31'd0, busy_b}, {31'd0, run_b > 0});
        if (dout_a === 1'b1 && prev_a === 1'b0) rises_a++;
        if (dout_b === 1'b1 && prev_b === 1'b0) rises_b++;
        if (busy_b === 1'b1) busy_b_seen = 1'b1;
        prev_a = dout_a;
        prev_b = dout_b;
    endtask

    task automatic applyStimulus(input logic rst_v, input logic din_v, input int n);
        rst       = rst_v;
        din_async = din_v;
        repeat (n) tick();
    endtask

    // Hold the input at a level and report the edge (1-based, from the first
    // edge that samples the level) at which each dout reaches target; 0 if never.
    task automatic measure(input logic target, output int ea, output int eb);
        ea = 0;
        eb = 0;
        din_async = target;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (ea == 0 && dout_a === target) ea = e;
            if (eb == 0 && dout_b === target) eb = e;
        end
    endtask

    initial begin
        int ea, eb, r0, rb, waited;
        bit seen;

        rst       = 1'b1;
        din_async = 1'b0;
        for (int i = 0; i < SYNC; i++) pipe[i] = 1'b0;
        m_dout_a = 1'b0;
        m_dout_b = 1'b0;
        run_a    = 0;
        run_b    = 0;

        // Reset held with the input high: outputs stay low throughout.
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("reset_dout", {31'd0, dout_a}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy_a}, 32'd0);

        // Release with the input high: it qualifies like any other rise.
        rst = 1'b0;
        measure(1'b1, ea, eb);
        checkOutput("post_reset_rise_edge_a", ea, 32'd6);
        checkOutput("post_reset_rise_edge_b", eb, 32'd3);

        // Fall from a settled high.
        measure(1'b0, ea, eb);
        checkOutput("fall_edge_a", ea, 32'd6);
        checkOutput("fall_edge_b", eb, 32'd3);

        // Clean rise with explicit busy window on edges 3..5.
        din_async = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checkOutput("clean_busy", {31'd0, busy_a}, {31'd0, (e >= 3 && e <= 5)});
            checkOutput("clean_dout", {31'd0, dout_a}, {31'd0, (e >= 6)});
        end

        // Settle low, then a 3-cycle glitch that must never reach dout_a.
        measure(1'b0, ea, eb);
        r0 = rises_a;
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("glitch_no_rise", rises_a - r0, 32'd0);
        checkOutput("glitch_busy_clear", {31'd0, busy_a}, 32'd0);

        // Bounce train, then a steady high: exactly one rise, 6 edges late.
        r0 = rises_a;
        for (int p = 0; p < 5; p++) begin
            applyStimulus(1'b0, 1'b1, 2);
            applyStimulus(1'b0, 1'b0, 2);
        end
        checkOutput("bounce_no_early_rise", rises_a - r0, 32'd0);
        measure(1'b1, ea, eb);
        checkOutput("bounce_rise_edge", ea, 32'd6);
        checkOutput("bounce_single_rise", rises_a - r0, 32'd1);

        // Start a fall, then reset mid-qualification.
        din_async = 1'b0;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 10) begin
            tick();
            waited++;
            if (busy_a === 1'b1) seen = 1'b1;
        end
        checkOutput("midcount_busy_seen", {31'd0, seen}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("midcount_rst_dout", {31'd0, dout_a}, 32'd0);
        checkOutput("midcount_rst_busy", {31'd0, busy_a}, 32'd0);
        checkOutput("midcount_rst_cnt", {30'd0, u_dut_a.cnt}, 32'd0);
        rst = 1'b0;

        // Randomized level runs with occasional resets.
        rb = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
                rst = 1'b0;
            end
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        rb = rb + 0;

        // DB_CNT=1 never shows a busy cycle.
        checkOutput("db1_busy_never", {31'd0, busy_b_seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
